// File: rtl/operand_fetch_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// operand_fetch_if : request, register-file read/writeback and response bus
// Rev 1.0
// ----------------------------------------------------------------------------
interface operand_fetch_if #(
  parameter int REG_COUNT = 32,
  parameter int REG_WIDTH = 32,
  parameter int TAG_WIDTH = 8
);
  localparam int AW = $clog2(REG_COUNT);

  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [AW-1:0]        req_src_1_i;
  logic [AW-1:0]        req_src_2_i;
  logic [TAG_WIDTH-1:0] req_tag_i;

  logic [AW-1:0]        rf_address_1_o;
  logic [AW-1:0]        rf_address_2_o;
  logic [REG_WIDTH-1:0] rf_rd_data_1_i;
  logic [REG_WIDTH-1:0] rf_rd_data_2_i;

  logic [AW-1:0]        wb_address_i;
  logic [REG_WIDTH-1:0] wb_data_i;
  logic                 wb_en_i;

  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [REG_WIDTH-1:0] rsp_operand_1_o;
  logic [REG_WIDTH-1:0] rsp_operand_2_o;
  logic [TAG_WIDTH-1:0] rsp_tag_o;

  // master is the operand-fetch stage itself; slave is the surrounding core
  modport master (
    input  req_valid_i, req_src_1_i, req_src_2_i, req_tag_i,
    input  rf_rd_data_1_i, rf_rd_data_2_i,
    input  wb_address_i, wb_data_i, wb_en_i,
    input  rsp_ready_i,
    output req_ready_o, rf_address_1_o, rf_address_2_o,
    output rsp_valid_o, rsp_operand_1_o, rsp_operand_2_o, rsp_tag_o
  );

  modport slave (
    output req_valid_i, req_src_1_i, req_src_2_i, req_tag_i,
    output rf_rd_data_1_i, rf_rd_data_2_i,
    output wb_address_i, wb_data_i, wb_en_i,
    output rsp_ready_i,
    input  req_ready_o, rf_address_1_o, rf_address_2_o,
    input  rsp_valid_o, rsp_operand_1_o, rsp_operand_2_o, rsp_tag_o
  );
endinterface
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// operand_fetch : two-stage register-file read with writeback forwarding
// Rev 1.0
// ----------------------------------------------------------------------------
module operand_fetch #(
  parameter int REG_COUNT = 32,
  parameter int REG_WIDTH = 32,
  parameter int TAG_WIDTH = 8
) (
  input  wire logic         clk_i,
  input  wire logic         reset_ni,
  operand_fetch_if.master   bus
);
  localparam int AW = $clog2(REG_COUNT);

  // S1: read in flight or held operands
  logic                 r_s1_valid;
  logic                 r_s1_have;
  logic                 r_s1_fwd_1;
  logic                 r_s1_fwd_2;
  logic [REG_WIDTH-1:0] r_s1_data_1;
  logic [REG_WIDTH-1:0] r_s1_data_2;
  logic [TAG_WIDTH-1:0] r_s1_tag;

  // S2: output register
  logic                 r_s2_valid;
  logic [REG_WIDTH-1:0] r_s2_op_1;
  logic [REG_WIDTH-1:0] r_s2_op_2;
  logic [TAG_WIDTH-1:0] r_s2_tag;

  logic                 w_s2_free;
  logic                 w_req_ready;
  logic                 w_accept;
  logic                 w_move;
  logic                 w_fwd_1;
  logic                 w_fwd_2;
  logic [REG_WIDTH-1:0] w_op_1;
  logic [REG_WIDTH-1:0] w_op_2;

  assign w_s2_free   = !r_s2_valid || bus.rsp_ready_i;
  assign w_req_ready = !r_s1_valid || w_s2_free;
  assign w_accept    = bus.req_valid_i && w_req_ready;
  assign w_move      = r_s1_valid && w_s2_free;

  // Writeback in the accept cycle lands after the RF samples its read address
  assign w_fwd_1 = bus.wb_en_i && (bus.wb_address_i == bus.req_src_1_i);
  assign w_fwd_2 = bus.wb_en_i && (bus.wb_address_i == bus.req_src_2_i);

  // The S1 data registers hold either forwarded data or latched read data
  assign w_op_1 = (r_s1_have || r_s1_fwd_1) ? r_s1_data_1 : bus.rf_rd_data_1_i;
  assign w_op_2 = (r_s1_have || r_s1_fwd_2) ? r_s1_data_2 : bus.rf_rd_data_2_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_s1_valid  <= 1'b0;
      r_s1_have   <= 1'b0;
      r_s1_fwd_1  <= 1'b0;
      r_s1_fwd_2  <= 1'b0;
      r_s1_data_1 <= '0;
      r_s1_data_2 <= '0;
      r_s1_tag    <= '0;
    end else if (w_accept) begin
      r_s1_valid  <= 1'b1;
      r_s1_have   <= 1'b0;
      r_s1_fwd_1  <= w_fwd_1;
      r_s1_fwd_2  <= w_fwd_2;
      r_s1_data_1 <= bus.wb_data_i;
      r_s1_data_2 <= bus.wb_data_i;
      r_s1_tag    <= bus.req_tag_i;
    end else if (w_move) begin
      r_s1_valid  <= 1'b0;
      r_s1_have   <= 1'b0;
      r_s1_fwd_1  <= 1'b0;
      r_s1_fwd_2  <= 1'b0;
    end else if (r_s1_valid && !r_s1_have) begin
      // RF data is only valid this one cycle, so capture it while stalled
      r_s1_data_1 <= w_op_1;
      r_s1_data_2 <= w_op_2;
      r_s1_have   <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_s2_valid <= 1'b0;
      r_s2_op_1  <= '0;
      r_s2_op_2  <= '0;
      r_s2_tag   <= '0;
    end else if (w_move) begin
      r_s2_valid <= 1'b1;
      r_s2_op_1  <= w_op_1;
      r_s2_op_2  <= w_op_2;
      r_s2_tag   <= r_s1_tag;
    end else if (bus.rsp_ready_i) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign bus.req_ready_o     = w_req_ready;
  assign bus.rf_address_1_o  = bus.req_src_1_i;
  assign bus.rf_address_2_o  = bus.req_src_2_i;
  assign bus.rsp_valid_o     = r_s2_valid;
  assign bus.rsp_operand_1_o = r_s2_op_1;
  assign bus.rsp_operand_2_o = r_s2_op_2;
  assign bus.rsp_tag_o       = r_s2_tag;

endmodule
`default_nettype wire
